// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the multicycle MIPS-subset CPU.
//   Holds the opcode/funct encodings, the control FSM state enum, the ALU
//   operation enum, the decoded-control struct, and the decode and
//   sign-extend helper functions used by the top-level controller and the
//   datapath.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] F_ADD = 6'd32;
    localparam logic [5:0] F_SUB = 6'd34;
    localparam logic [5:0] F_AND = 6'd36;
    localparam logic [5:0] F_OR  = 6'd37;
    localparam logic [5:0] F_SLT = 6'd42;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_NOP = 3'd5
    } alu_op_t;

    typedef struct packed {
        alu_op_t    aluOp;
        logic       useImm;
        logic       regWrite;
        logic       memWrite;
        logic       memToReg;
        logic [4:0] destReg;
    } ctrl_t;

    function automatic logic [31:0] signExtend(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    // Unsupported opcodes/functs fall out with every write enable cleared,
    // which turns them into a NOP that still walks through all FSM states.
    function automatic ctrl_t decodeInstr(input logic [5:0] op,
                                          input logic [5:0] funct,
                                          input logic [4:0] rt,
                                          input logic [4:0] rd);
        ctrl_t c;
        c.aluOp    = ALU_NOP;
        c.useImm   = 1'b0;
        c.regWrite = 1'b0;
        c.memWrite = 1'b0;
        c.memToReg = 1'b0;
        c.destReg  = 5'd0;
        case (op)
            OP_RTYPE: begin
                c.destReg = rd;
                c.regWrite = 1'b1;
                case (funct)
                    F_ADD:   c.aluOp = ALU_ADD;
                    F_SUB:   c.aluOp = ALU_SUB;
                    F_AND:   c.aluOp = ALU_AND;
                    F_OR:    c.aluOp = ALU_OR;
                    F_SLT:   c.aluOp = ALU_SLT;
                    default: c.regWrite = 1'b0;
                endcase
            end
            OP_ADDI: begin
                c.aluOp    = ALU_ADD;
                c.useImm   = 1'b1;
                c.regWrite = 1'b1;
                c.destReg  = rt;
            end
            OP_LW: begin
                c.aluOp    = ALU_ADD;
                c.useImm   = 1'b1;
                c.regWrite = 1'b1;
                c.memToReg = 1'b1;
                c.destReg  = rt;
            end
            OP_SW: begin
                c.aluOp    = ALU_ADD;
                c.useImm   = 1'b1;
                c.memWrite = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_datapath.sv
// mips_datapath
//   Register file, ALU and data memory for the multicycle CPU. Each FSM
//   phase is driven by a one-cycle load strobe from the controller.
//   Ports:
//     clock, reset  - clock and asynchronous active-low reset
//     i_rs, i_rt    - source register numbers
//     i_imm         - raw 16-bit immediate
//     i_aluOp       - ALU operation
//     i_useImm      - ALU B operand is the sign-extended immediate
//     i_memToReg    - writeback takes memory data instead of ALU result
//     i_destReg     - writeback register number
//     i_ldOperands  - DECODE phase: latch rs/rt values and immediate
//     i_ldAlu       - EXEC phase: latch ALU result
//     i_memWe       - MEM phase: store rt value at the effective address
//     i_ldMem       - MEM phase: latch load data
//     i_regWe       - WB phase: write the register file
module mips_datapath
    import mips_pkg::*;
#(
    parameter int DMEM_WORDS = 256
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    input  logic [15:0] i_imm,
    input  alu_op_t    i_aluOp,
    input  logic       i_useImm,
    input  logic       i_memToReg,
    input  logic [4:0] i_destReg,
    input  logic       i_ldOperands,
    input  logic       i_ldAlu,
    input  logic       i_memWe,
    input  logic       i_ldMem,
    input  logic       i_regWe
);

    localparam int AW = $clog2(DMEM_WORDS);

    logic [31:0] regFile [0:31];

    logic [31:0] r_rsVal;
    logic [31:0] r_rtVal;
    logic [31:0] r_imm;
    logic [31:0] r_aluResult;
    logic [31:0] r_memData;

    logic [31:0] w_aluB;
    logic [31:0] w_aluResult;
    logic [31:0] w_memRdata;
    logic [31:0] w_wbData;

    // ALU: wrap-around arithmetic, slt compares as signed.
    always_comb begin
        w_aluB = i_useImm ? r_imm : r_rtVal;
        w_aluResult = 32'd0;
        case (i_aluOp)
            ALU_ADD: w_aluResult = r_rsVal + w_aluB;
            ALU_SUB: w_aluResult = r_rsVal - w_aluB;
            ALU_AND: w_aluResult = r_rsVal & w_aluB;
            ALU_OR:  w_aluResult = r_rsVal | w_aluB;
            ALU_SLT: w_aluResult = {31'd0, $signed(r_rsVal) < $signed(w_aluB)};
            default: w_aluResult = 32'd0;
        endcase
    end

    assign w_wbData = i_memToReg ? r_memData : r_aluResult;

    // Phase registers and register file; $0 is never written and reads are
    // forced to zero so it stays hard-wired regardless of its storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regFile[i] <= 32'd0;
            end
            r_rsVal     <= 32'd0;
            r_rtVal     <= 32'd0;
            r_imm       <= 32'd0;
            r_aluResult <= 32'd0;
            r_memData   <= 32'd0;
        end else begin
            if (i_ldOperands) begin
                r_rsVal <= (i_rs == 5'd0) ? 32'd0 : regFile[i_rs];
                r_rtVal <= (i_rt == 5'd0) ? 32'd0 : regFile[i_rt];
                r_imm   <= signExtend(i_imm);
            end
            if (i_ldAlu) begin
                r_aluResult <= w_aluResult;
            end
            if (i_ldMem) begin
                r_memData <= w_memRdata;
            end
            if (i_regWe && (i_destReg != 5'd0)) begin
                regFile[i_destReg] <= w_wbData;
            end
        end
    end

    // Effective address is truncated to the memory depth, so it wraps.
    mips_dmem #(
        .DMEM_WORDS(DMEM_WORDS)
    ) memory_instance (
        .clock   (clock),
        .reset   (reset),
        .i_addr  (r_aluResult[AW-1:0]),
        .i_we    (i_memWe),
        .i_wdata (r_rtVal),
        .o_rdata (w_memRdata)
    );

endmodule

// File: rtl/mips_dmem.sv
// mips_dmem
//   Word-addressed data memory, cleared to zero by the asynchronous reset.
//   Ports:
//     clock   - rising-edge clock
//     reset   - asynchronous active-low reset, clears every word
//     i_addr  - word index (already truncated to the memory depth)
//     i_we    - write enable for i_wdata at i_addr
//     i_wdata - write data
//     o_rdata - combinational read data at i_addr
module mips_dmem #(
    parameter int DMEM_WORDS = 256
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [$clog2(DMEM_WORDS)-1:0] i_addr,
    input  logic                          i_we,
    input  logic [31:0]                   i_wdata,
    output logic [31:0]                   o_rdata
);

    logic [31:0] memoryFile [0:DMEM_WORDS-1];

    // Whole-array clear on reset so an aborted store can never leave a word behind.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DMEM_WORDS; i++) begin
                memoryFile[i] <= 32'd0;
            end
        end else if (i_we) begin
            memoryFile[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = memoryFile[i_addr];

endmodule

// File: rtl/mips_cpu.sv
// mips_cpu
//   Multicycle MIPS-subset core executing one host-supplied instruction per
//   rising edge of newinstr. The controller walks every instruction through
//   IDLE -> DECODE -> EXEC -> MEM -> WB -> IDLE and issues one-cycle phase
//   strobes to the datapath. No outputs; state is observed hierarchically.
//   Ports:
//     reset     - asynchronous active-low reset
//     clock     - rising-edge clock
//     instrword - instruction, stable from the newinstr rise until retire
//     newinstr  - start strobe, acted on only on a 0->1 change while IDLE
module mips_cpu
    import mips_pkg::*;
#(
    parameter int DMEM_WORDS = 256
) (
    input  logic        reset,
    input  logic        clock,
    input  logic [31:0] instrword,
    input  logic        newinstr
);

    state_t      r_state;
    logic [31:0] r_instr;
    logic        r_newinstrPrev;
    logic        r_ldOperands;
    logic        r_ldAlu;
    logic        r_memWe;
    logic        r_ldMem;
    logic        r_regWe;

    ctrl_t       w_ctrl;

    assign w_ctrl = decodeInstr(r_instr[31:26], r_instr[5:0], r_instr[20:16], r_instr[15:11]);

    // Control FSM. Each phase strobe is registered on entry into its state,
    // so it is high for exactly the cycle the FSM spends there. A rise of
    // newinstr outside IDLE is simply lost; it is not remembered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_instr        <= 32'd0;
            r_newinstrPrev <= 1'b0;
            r_ldOperands   <= 1'b0;
            r_ldAlu        <= 1'b0;
            r_memWe        <= 1'b0;
            r_ldMem        <= 1'b0;
            r_regWe        <= 1'b0;
        end else begin
            r_newinstrPrev <= newinstr;
            r_ldOperands   <= 1'b0;
            r_ldAlu        <= 1'b0;
            r_memWe        <= 1'b0;
            r_ldMem        <= 1'b0;
            r_regWe        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (newinstr && !r_newinstrPrev) begin
                        r_instr      <= instrword;
                        r_state      <= S_DECODE;
                        r_ldOperands <= 1'b1;
                    end
                end
                S_DECODE: begin
                    r_state <= S_EXEC;
                    r_ldAlu <= 1'b1;
                end
                S_EXEC: begin
                    r_state <= S_MEM;
                    r_memWe <= w_ctrl.memWrite;
                    r_ldMem <= w_ctrl.memToReg;
                end
                S_MEM: begin
                    r_state <= S_WB;
                    r_regWe <= w_ctrl.regWrite;
                end
                S_WB: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    mips_datapath #(
        .DMEM_WORDS(DMEM_WORDS)
    ) myDatapath (
        .clock        (clock),
        .reset        (reset),
        .i_rs         (r_instr[25:21]),
        .i_rt         (r_instr[20:16]),
        .i_imm        (r_instr[15:0]),
        .i_aluOp      (w_ctrl.aluOp),
        .i_useImm     (w_ctrl.useImm),
        .i_memToReg   (w_ctrl.memToReg),
        .i_destReg    (w_ctrl.destReg),
        .i_ldOperands (r_ldOperands),
        .i_ldAlu      (r_ldAlu),
        .i_memWe      (r_memWe),
        .i_ldMem      (r_ldMem),
        .i_regWe      (r_regWe)
    );

endmodule

// File: tb/tb_mips_cpu.sv
// tb_mips_cpu
//   Drives directed instruction sequences into mips_cpu and compares the
//   register file and data memory against an instruction-level model.
module tb_mips_cpu;
    import mips_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        newinstr = 1'b0;
    logic [31:0] instrword = 32'd0;

    int testsRun = 0;
    int testsFailed = 0;

    logic [31:0] mReg [32];
    logic [31:0] mMem [256];

    mips_cpu #(
        .DMEM_WORDS(256)
    ) dut (
        .reset     (reset),
        .clock     (clock),
        .instrword (instrword),
        .newinstr  (newinstr)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rType(input int rs, input int rt, input int rd, input int funct);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
    endfunction

    function automatic logic [31:0] iType(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 32; i++) mReg[i] = 32'd0;
        for (int i = 0; i < 256; i++) mMem[i] = 32'd0;
    endfunction

    // Instruction-level semantics: one call applies one whole instruction.
    function automatic void modelExec(input logic [31:0] ins);
        logic [31:0] a, b, imm, ea, res;
        logic        wr;
        int          dest;
        a    = mReg[ins[25:21]];
        b    = mReg[ins[20:16]];
        imm  = {{16{ins[15]}}, ins[15:0]};
        ea   = a + imm;
        wr   = 1'b0;
        res  = 32'd0;
        dest = 0;
        case (int'(ins[31:26]))
            0: begin
                dest = int'(ins[15:11]);
                wr = 1'b1;
                case (int'(ins[5:0]))
                    32: res = a + b;
                    34: res = a - b;
                    36: res = a & b;
                    37: res = a | b;
                    42: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: wr = 1'b0;
                endcase
            end
            8:  begin dest = int'(ins[20:16]); res = ea; wr = 1'b1; end
            35: begin dest = int'(ins[20:16]); res = mMem[ea[7:0]]; wr = 1'b1; end
            43: mMem[ea[7:0]] = b;
            default: ;
        endcase
        if (wr && dest != 0) mReg[dest] = res;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Full architectural-state compare against the model.
    task automatic checkOutput(input string tag);
        for (int i = 0; i < 32; i++)
            checkValue($sformatf("%s reg%0d", tag, i), dut.myDatapath.regFile[i], mReg[i]);
        for (int i = 0; i < 256; i++)
            checkValue($sformatf("%s mem%0d", tag, i), dut.myDatapath.memory_instance.memoryFile[i], mMem[i]);
        checkValue($sformatf("%s idle", tag), 32'(dut.r_state), 32'(S_IDLE));
    endtask

    // Short holds are checked exactly five edges after the start edge.
    task automatic applyStimulus(input logic [31:0] ins, input int hold);
        @(negedge clock);
        instrword = ins;
        newinstr = 1'b1;
        repeat (hold) @(negedge clock);
        newinstr = 1'b0;
        repeat ((hold < 5) ? (5 - hold) : 6) @(negedge clock);
        modelExec(ins);
        checkOutput($sformatf("instr %h", ins));
    endtask

    initial begin
        modelReset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("reset");

        // Preload memory words 0..2 with 10, 22, 10 through the CPU itself.
        applyStimulus(iType(8, 0, 1, 10), 1);
        applyStimulus(iType(43, 0, 1, 0), 1);
        applyStimulus(iType(8, 0, 1, 22), 1);
        applyStimulus(iType(43, 0, 1, 1), 1);
        applyStimulus(iType(8, 0, 1, 10), 1);
        applyStimulus(iType(43, 0, 1, 2), 1);

        // a + b - c program
        applyStimulus(iType(35, 0, 1, 0), 1);
        applyStimulus(iType(35, 0, 2, 1), 1);
        applyStimulus(iType(35, 0, 3, 2), 1);
        applyStimulus(rType(1, 2, 4, 32), 1);
        applyStimulus(rType(4, 3, 5, 34), 1);
        applyStimulus(iType(43, 0, 5, 3), 1);
        checkValue("prog reg4", dut.myDatapath.regFile[4], 32'd32);
        checkValue("prog reg5", dut.myDatapath.regFile[5], 32'd22);
        checkValue("prog mem3", dut.myDatapath.memory_instance.memoryFile[3], 32'd22);

        // Writes to $0 are discarded
        applyStimulus(rType(1, 2, 0, 32), 1);
        applyStimulus(rType(0, 0, 6, 32), 1);
        checkValue("zero reg0", dut.myDatapath.regFile[0], 32'd0);
        checkValue("zero reg6", dut.myDatapath.regFile[6], 32'd0);

        // Negative offset, negative result, signed slt
        applyStimulus(iType(8, 0, 7, 5), 1);
        applyStimulus(iType(35, 7, 8, -2), 1);
        applyStimulus(iType(8, 0, 11, 3), 1);
        applyStimulus(rType(11, 7, 12, 34), 1);
        applyStimulus(rType(12, 0, 13, 42), 1);
        applyStimulus(rType(0, 12, 19, 42), 1);
        checkValue("neg lw reg8", dut.myDatapath.regFile[8], 32'd22);
        checkValue("neg sub reg12", dut.myDatapath.regFile[12], 32'hFFFF_FFFE);
        checkValue("slt reg13", dut.myDatapath.regFile[13], 32'd1);
        checkValue("slt reg19", dut.myDatapath.regFile[19], 32'd0);

        // and/or, address wrap, unsupported encodings
        applyStimulus(rType(1, 2, 16, 36), 1);
        applyStimulus(rType(1, 2, 17, 37), 1);
        applyStimulus(iType(8, 0, 14, -1), 1);
        applyStimulus(iType(43, 14, 5, 0), 1);
        applyStimulus(iType(35, 0, 15, 256), 1);
        applyStimulus(rType(1, 2, 20, 0), 1);
        applyStimulus(iType(2, 1, 21, 7), 1);
        checkValue("and reg16", dut.myDatapath.regFile[16], 32'd2);
        checkValue("or reg17", dut.myDatapath.regFile[17], 32'd30);
        checkValue("wrap mem255", dut.myDatapath.memory_instance.memoryFile[255], 32'd22);
        checkValue("wrap reg15", dut.myDatapath.regFile[15], 32'd10);

        // Held-high strobe executes exactly once
        applyStimulus(iType(8, 10, 10, 1), 7);
        checkValue("held reg10", dut.myDatapath.regFile[10], 32'd1);

        // Second rise while busy is dropped, even if left high afterwards
        @(negedge clock);
        instrword = iType(8, 18, 18, 100);
        newinstr = 1'b1;
        @(negedge clock);
        newinstr = 1'b0;
        @(negedge clock);
        newinstr = 1'b1;
        repeat (6) @(negedge clock);
        newinstr = 1'b0;
        repeat (6) @(negedge clock);
        modelExec(iType(8, 18, 18, 100));
        checkOutput("second rise");
        checkValue("rise reg18", dut.myDatapath.regFile[18], 32'd100);

        // Reset during the MEM cycle of a store aborts it
        @(negedge clock);
        instrword = iType(43, 0, 5, 4);
        newinstr = 1'b1;
        @(negedge clock);
        newinstr = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkValue("abort in MEM", 32'(dut.r_state), 32'(S_MEM));
        reset = 1'b0;
        #1;
        checkValue("abort mem4", dut.myDatapath.memory_instance.memoryFile[4], 32'd0);
        @(negedge clock);
        reset = 1'b1;
        modelReset();
        repeat (2) @(negedge clock);
        checkOutput("mid reset");

        // Core operates normally after the abort
        applyStimulus(iType(8, 0, 1, 7), 1);
        checkValue("post reset reg1", dut.myDatapath.regFile[1], 32'd7);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
